// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory-interface definitions: request types, register map, RAM layout.
// Imported by the memory controller, its register file and the processor.
package chip8_pkg;

  typedef enum logic [1:0] {
    PROC_MEM_TYPE_REG = 2'd0,
    PROC_MEM_TYPE_RAM = 2'd1
  } proc_mem_type_e;

  // Source of the byte returned by a read, carried down the response pipeline.
  typedef enum logic [1:0] {
    RD_SRC_REG  = 2'd0,
    RD_SRC_RAM  = 2'd1,
    RD_SRC_ZERO = 2'd2
  } rd_src_e;

  localparam logic [4:0] REG_V0  = 5'd0;
  localparam logic [4:0] REG_V1  = 5'd1;
  localparam logic [4:0] REG_V2  = 5'd2;
  localparam logic [4:0] REG_V3  = 5'd3;
  localparam logic [4:0] REG_V4  = 5'd4;
  localparam logic [4:0] REG_V5  = 5'd5;
  localparam logic [4:0] REG_V6  = 5'd6;
  localparam logic [4:0] REG_V7  = 5'd7;
  localparam logic [4:0] REG_V8  = 5'd8;
  localparam logic [4:0] REG_V9  = 5'd9;
  localparam logic [4:0] REG_VA  = 5'd10;
  localparam logic [4:0] REG_VB  = 5'd11;
  localparam logic [4:0] REG_VC  = 5'd12;
  localparam logic [4:0] REG_VD  = 5'd13;
  localparam logic [4:0] REG_VE  = 5'd14;
  localparam logic [4:0] REG_VF  = 5'd15;
  localparam logic [4:0] REG_IH  = 5'd16;
  localparam logic [4:0] REG_IL  = 5'd17;
  localparam logic [4:0] REG_PCH = 5'd18;
  localparam logic [4:0] REG_PCL = 5'd19;
  localparam logic [4:0] REG_DT  = 5'd20;
  localparam logic [4:0] REG_ST  = 5'd21;
  localparam logic [4:0] REG_SP  = 5'd22;

  // Addresses above REG_SP are unbacked: they read 0 and ignore writes.
  localparam int REG_NUM = 23;

  localparam logic [11:0] CHIP8_RAM_BASE = 12'h200;

  function automatic logic reg_addr_valid(input logic [4:0] addr);
    return addr <= REG_SP;
  endfunction

endpackage

// File: rtl/chip8_reg_file.sv
// CHIP-8 register file (V0-VF, I, PC, DT, ST, SP) with 60 Hz timers.
// 1-cycle registered read, synchronous write; a write to DT/ST beats a same-cycle decrement.
module chip8_reg_file
  import chip8_pkg::*;
#(
  parameter logic [11:0] PC_RESET = 12'h200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [4:0] addr_i,
  input  logic       we_i,
  input  logic [7:0] wdata_i,
  input  logic       timer_decr_i,
  output logic [7:0] rdata_o,
  output logic [7:0] st_o
);

  logic [7:0] regs_q [REG_NUM];
  logic [7:0] regs_d [REG_NUM];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (timer_decr_i) begin
      if (regs_q[REG_DT] != 8'd0) regs_d[REG_DT] = regs_q[REG_DT] - 8'd1;
      if (regs_q[REG_ST] != 8'd0) regs_d[REG_ST] = regs_q[REG_ST] - 8'd1;
    end
    if (we_i && reg_addr_valid(addr_i)) begin
      regs_d[addr_i] = wdata_i;
    end
    // Read samples the pre-update value, so a DT read shows the accept-cycle count.
    rdata_d = reg_addr_valid(addr_i) ? regs_q[addr_i] : 8'd0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= 8'd0;
      end
      regs_q[REG_PCH] <= {4'h0, PC_RESET[11:8]};
      regs_q[REG_PCL] <= PC_RESET[7:0];
      rdata_q         <= 8'd0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign st_o    = regs_q[REG_ST];

endmodule

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 memory front-end: 4 KiB RAM, register file and timers; reads respond 2 cycles after accept.
// Defining CHIP8_MEM_WRPROT_EN drops processor RAM writes below 0x200 and flags error_out[1].
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter int          RAM_DEPTH = 4096,
  parameter string       INIT_FILE = "",
  parameter logic [11:0] PC_RESET  = 12'h200
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] proc_addr_in,
  input  logic        proc_we_in,
  input  logic        proc_valid_in,
  input  logic [7:0]  proc_data_in,
  input  logic [1:0]  proc_type_in,
  output logic        proc_ready_out,
  output logic        proc_valid_out,
  output logic [7:0]  proc_data_out,
  input  logic [11:0] load_addr_in,
  input  logic [7:0]  load_data_in,
  input  logic        load_valid_in,
  input  logic        timer_decr_in,
  output logic        active_audio_out,
  output logic [1:0]  error_out
);

  logic        accept;
  logic        is_reg;
  logic        is_ram;
  logic        is_ill;
  logic        wp_hit;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  ram_rd_q;
  logic [7:0]  reg_rdata;
  logic [7:0]  st_val;

  logic        rd1_vld_q, rd1_vld_d;
  rd_src_e     rd1_src_q, rd1_src_d;
  logic        vld_q, vld_d;
  logic [7:0]  dat_q, dat_d;
  logic [1:0]  err_q, err_d;
  logic        audio_q, audio_d;

  assign proc_ready_out = !rst_in && !load_valid_in;
  assign accept         = proc_valid_in && proc_ready_out;
  assign is_reg         = proc_type_in == PROC_MEM_TYPE_REG;
  assign is_ram         = proc_type_in == PROC_MEM_TYPE_RAM;
  assign is_ill         = !is_reg && !is_ram;

`ifdef CHIP8_MEM_WRPROT_EN
  assign wp_hit = accept && proc_we_in && is_ram && (proc_addr_in < CHIP8_RAM_BASE);
`else
  assign wp_hit = 1'b0;
`endif

  // Single RAM port: the loader owns it whenever it is active, since the processor is stalled.
  assign ram_we    = load_valid_in || (accept && proc_we_in && is_ram && !wp_hit);
  assign ram_addr  = load_valid_in ? load_addr_in : proc_addr_in;
  assign ram_wdata = load_valid_in ? load_data_in : proc_data_in;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= ram_wdata;
    ram_rd_q <= ram_q[ram_addr];
  end

  chip8_reg_file #(
    .PC_RESET(PC_RESET)
  ) u_reg_file (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .addr_i      (proc_addr_in[4:0]),
    .we_i        (accept && proc_we_in && is_reg),
    .wdata_i     (proc_data_in),
    .timer_decr_i(timer_decr_in),
    .rdata_o     (reg_rdata),
    .st_o        (st_val)
  );

  always_comb begin
    rd1_vld_d = accept && !proc_we_in;
    rd1_src_d = is_reg ? RD_SRC_REG : (is_ram ? RD_SRC_RAM : RD_SRC_ZERO);
    vld_d     = rd1_vld_q;
    dat_d     = dat_q;
    if (rd1_vld_q) begin
      case (rd1_src_q)
        RD_SRC_REG: dat_d = reg_rdata;
        RD_SRC_RAM: dat_d = ram_rd_q;
        default:    dat_d = 8'd0;
      endcase
    end
    err_d   = err_q | {wp_hit, accept && is_ill};
    audio_d = st_val != 8'd0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd1_vld_q <= 1'b0;
      rd1_src_q <= RD_SRC_ZERO;
      vld_q     <= 1'b0;
      dat_q     <= 8'd0;
      err_q     <= 2'b00;
      audio_q   <= 1'b0;
    end else begin
      rd1_vld_q <= rd1_vld_d;
      rd1_src_q <= rd1_src_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
      audio_q   <= audio_d;
    end
  end

  assign proc_valid_out   = vld_q;
  assign proc_data_out    = dat_q;
  assign error_out        = err_q;
  assign active_audio_out = audio_q;

endmodule
